mmcm_drp_reconfig: RTL and testbench
====================================

Name: mmcm_drp_reconfig

Overview:
- DRP initiator that reprograms an MMCM_ADV/MMCME2_ADV at run time by walking a table of register entries.
- Each entry is applied as a read-modify-write: DEN/DWE/DADDR/DI out, DO/DRDY in.
- Holds the MMCM in reset for the whole sequence, then releases it and waits for LOCKED.
- Sits between the clocking wrapper and the system control logic that selects clock profiles.

Parameters:
- NUM_ENTRIES, 23, number of table entries applied per START (1..128).
- TBL_AW, 7, table address width; NUM_ENTRIES <= 2**TBL_AW.
- DRDY_TIMEOUT, 64, DCLK cycles to wait for DRDY after any DEN before flagging an error.
- LOCK_TIMEOUT, 65535, DCLK cycles to wait for LOCKED after reset release before flagging an error.

Ports:
- DCLK input 1: the single clock, also drives the MMCM DCLK.
- RST input 1: synchronous reset, active-high.
- START input 1: one-cycle request; accepted only in IDLE.
- BUSY output 1: high from the cycle after START is accepted until DONE.
- DONE output 1: one-cycle pulse when the sequence ends, on success or error.
- ERR output 1: sticky error flag; cleared on the next accepted START or on RST.
- ERR_CODE output 2: 0 = none, 1 = DRDY timeout, 2 = LOCKED timeout; updated with ERR.
- TBL_ADDR output TBL_AW: table read address.
- TBL_DATA input 39: entry {addr[38:32], mask[31:16], data[15:0]}; valid one cycle after TBL_ADDR.
- DADDR output 7: DRP address.
- DEN output 1: DRP enable, one-cycle pulse.
- DWE output 1: DRP write enable; high only together with DEN.
- DI output 16: DRP write data.
- DO input 16: DRP read data; valid when DRDY=1.
- DRDY input 1: DRP transaction complete.
- MMCM_RST output 1: drives the MMCM RST pin.
- LOCKED input 1: MMCM LOCKED.

Behaviour:
- Reset values:
  - MMCM_RST = 0.
  - BUSY, DONE, ERR, DEN, DWE = 0.
  - ERR_CODE, DADDR, DI, TBL_ADDR = 0.
  - Entry index = 0; FSM in IDLE.
- FSM states: IDLE, FETCH, LATCH, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, LOCK_WAIT, FINISH.
- IDLE:
  - START=1 -> FETCH. In the same edge: MMCM_RST <= 1, index <= 0, TBL_ADDR <= 0, ERR <= 0, ERR_CODE <= 0, BUSY <= 1.
- FETCH: wait one cycle for table read latency.
- LATCH: register addr, mask and data from TBL_DATA; -> RD_REQ.
- RD_REQ: DEN=1, DWE=0, DADDR=addr for exactly one cycle; clear timeout counter; -> RD_WAIT.
- RD_WAIT:
  - On DRDY: new = (DO & mask) | (data & ~mask). Mask bit 1 keeps the existing bit. Register new into DI; -> WR_REQ.
- WR_REQ: DEN=1, DWE=1, DADDR=addr, DI=new for exactly one cycle; clear timeout counter; -> WR_WAIT.
- WR_WAIT: on DRDY -> NEXT.
- NEXT:
  - If index == NUM_ENTRIES-1: MMCM_RST <= 0, clear lock counter; -> LOCK_WAIT.
  - Otherwise: index++, TBL_ADDR <= index+1; -> FETCH.
- LOCK_WAIT: LOCKED=1 -> FINISH. LOCKED is sampled only after reset release; a stale LOCKED during the sequence is ignored.
- FINISH: DONE=1 for one cycle, BUSY <= 0; -> IDLE.
- DRP rules:
  - Only one outstanding DRP transaction at a time.
  - DEN is never asserted in RD_WAIT or WR_WAIT.
  - DRDY outside RD_WAIT/WR_WAIT is ignored.
- Timeouts:
  - Counter runs in RD_WAIT/WR_WAIT. Counter reaching DRDY_TIMEOUT -> ERR <= 1, ERR_CODE <= 1, MMCM_RST <= 0; -> FINISH.
  - Lock counter reaching LOCK_TIMEOUT -> ERR <= 1, ERR_CODE <= 2; -> FINISH. MMCM_RST stays 0.
- START while BUSY is ignored and has no effect.
- Per-entry DRP latency with DRDY returning k cycles after DEN: FETCH(1) + LATCH(1) + RD_REQ(1) + k + WR_REQ(1) + k + NEXT(1).
- RST mid-sequence: all outputs return to reset values on the next edge, MMCM_RST drops to 0, and no DONE pulse is issued.

Test Plan:
- Single-entry RMW, NUM_ENTRIES=1, DRP model DRDY 3 cycles after DEN: entry {0x08, mask 0x1000, data 0x0041}, DO=0xF3C7 -> one read of DADDR 0x08, then one write of DI=0x1041 to 0x08; MMCM_RST high from the cycle after START until NEXT; LOCKED after 10 cycles -> DONE pulse, ERR=0.
- Full table, NUM_ENTRIES=23, DRDY latency 1: exactly 23 reads and 23 writes in table order, addresses matching the table, each DEN one cycle wide, DWE=1 only on writes; BUSY stays high throughout.
- DRDY never returns on entry 5, DRDY_TIMEOUT=64 -> ERR=1, ERR_CODE=1 at 64 cycles after that DEN; MMCM_RST=0; DONE pulse; no further DEN.
- LOCKED held 0, LOCK_TIMEOUT=100 -> ERR_CODE=2 and DONE 100 cycles after MMCM_RST falls; the next START clears ERR, and a normal rerun ends with ERR=0.
- START asserted while BUSY, plus a spurious DRDY while in FETCH -> no extra DRP transaction; the sequence result is identical to the undisturbed run.
- RST asserted during WR_WAIT of entry 2 -> next edge: MMCM_RST=0, BUSY=0, DEN=0, no DONE; a subsequent START restarts from TBL_ADDR=0.

Source files
------------

// File: rtl/mmcm_drp_reconfig_if.sv
// Bundle of control, table and DRP/MMCM signals between the reconfig
// engine (master) and the clocking wrapper / profile logic (slave).
interface mmcm_drp_reconfig_if #(
  parameter int TBL_AW = 7
);
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [TBL_AW-1:0] tbl_addr;
  logic [38:0]       tbl_data;
  logic [6:0]        daddr;
  logic              den;
  logic              dwe;
  logic [15:0]       di;
  logic [15:0]       do_data;
  logic              drdy;
  logic              mmcm_rst;
  logic              locked;

  modport master (
    input  start, tbl_data, do_data, drdy, locked,
    output busy, done, err, err_code, tbl_addr, daddr, den, dwe, di, mmcm_rst
  );

  modport slave (
    output start, tbl_data, do_data, drdy, locked,
    input  busy, done, err, err_code, tbl_addr, daddr, den, dwe, di, mmcm_rst
  );
endinterface

// File: rtl/mmcm_drp_reconfig.sv
// DRP initiator: walks a register table, applying each entry to the MMCM as a
// read-modify-write while holding it in reset, then waits for LOCKED.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | table read latency cycle
// LATCH     | capture addr/mask/data, raise read DEN
// RD_REQ    | read DEN on the bus
// RD_WAIT   | waiting for read DRDY, merge DO with table data
// WR_REQ    | write DEN/DWE on the bus
// WR_WAIT   | waiting for write DRDY
// NEXT      | advance entry or release MMCM reset
// LOCK_WAIT | waiting for LOCKED after reset release
// FINISH    | done pulse, drop busy
module mmcm_drp_reconfig #(
  parameter int NUM_ENTRIES  = 23,
  parameter int TBL_AW       = 7,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rst,
  mmcm_drp_reconfig_if.master bus
);
  localparam int DCW = $clog2(DRDY_TIMEOUT + 1);
  localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TBL_AW-1:0] LAST_IDX  = TBL_AW'(NUM_ENTRIES - 1);
  localparam logic [DCW-1:0]    DRDY_LAST = DCW'(DRDY_TIMEOUT - 1);
  localparam logic [LCW-1:0]    LOCK_LAST = LCW'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, LOCK_WAIT, FINISH
  } state_t;

  state_t            state;
  logic [TBL_AW-1:0] idx;
  logic [TBL_AW-1:0] tbl_addr;
  logic [15:0]       mask;
  logic [15:0]       data;
  logic [DCW-1:0]    drdy_cnt;
  logic [LCW-1:0]    lock_cnt;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [6:0]        daddr;
  logic              den;
  logic              dwe;
  logic [15:0]       di;
  logic              mmcm_rst;
  logic [15:0]       merged;
  logic              drdy_expired;

  // mask bit 1 keeps the bit currently in the MMCM register
  assign merged       = (bus.do_data & mask) | (data & ~mask);
  assign drdy_expired = (drdy_cnt == DRDY_LAST);

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.err_code = err_code;
  assign bus.tbl_addr = tbl_addr;
  assign bus.daddr    = daddr;
  assign bus.den      = den;
  assign bus.dwe      = dwe;
  assign bus.di       = di;
  assign bus.mmcm_rst = mmcm_rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      tbl_addr <= '0;
      mask     <= '0;
      data     <= '0;
      drdy_cnt <= '0;
      lock_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      daddr    <= '0;
      den      <= 1'b0;
      dwe      <= 1'b0;
      di       <= '0;
      mmcm_rst <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= FETCH;
            mmcm_rst <= 1'b1;
            idx      <= '0;
            tbl_addr <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
            busy     <= 1'b1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          daddr <= bus.tbl_data[38:32];
          mask  <= bus.tbl_data[31:16];
          data  <= bus.tbl_data[15:0];
          den   <= 1'b1;
          dwe   <= 1'b0;
          state <= RD_REQ;
        end
        RD_REQ: begin
          den      <= 1'b0;
          // counter holds cycles elapsed since the DEN cycle
          drdy_cnt <= DCW'(1);
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.drdy) begin
            di    <= merged;
            den   <= 1'b1;
            dwe   <= 1'b1;
            state <= WR_REQ;
          end else if (drdy_expired) begin
            err      <= 1'b1;
            err_code <= 2'd1;
            mmcm_rst <= 1'b0;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            drdy_cnt <= drdy_cnt + 1'b1;
          end
        end
        WR_REQ: begin
          den      <= 1'b0;
          dwe      <= 1'b0;
          drdy_cnt <= DCW'(1);
          state    <= WR_WAIT;
        end
        WR_WAIT: begin
          if (bus.drdy) begin
            state <= NEXT;
          end else if (drdy_expired) begin
            err      <= 1'b1;
            err_code <= 2'd1;
            mmcm_rst <= 1'b0;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            drdy_cnt <= drdy_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            mmcm_rst <= 1'b0;
            lock_cnt <= '0;
            state    <= LOCK_WAIT;
          end else begin
            idx      <= idx + 1'b1;
            tbl_addr <= idx + 1'b1;
            state    <= FETCH;
          end
        end
        LOCK_WAIT: begin
          if (bus.locked) begin
            done  <= 1'b1;
            state <= FINISH;
          end else if (lock_cnt == LOCK_LAST) begin
            err      <= 1'b1;
            err_code <= 2'd2;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Scoreboard bench for mmcm_drp_reconfig: a DRP responder, table ROM and
// LOCKED model drive the DUT; a monitor compares DRP traffic and results.
module tb_mmcm_drp_reconfig;
  localparam int N  = 23;
  localparam int AW = 7;
  localparam int DT = 64;
  localparam int LT = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmcm_drp_reconfig_if #(.TBL_AW(AW)) bus ();

  mmcm_drp_reconfig #(
    .NUM_ENTRIES(N), .TBL_AW(AW), .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed { logic wr; logic [6:0] addr; logic [15:0] data; } txn_t;
  typedef struct packed { logic err; logic [1:0] code; } res_t;

  int checks = 0;
  int failures = 0;

  logic [38:0] table_mem [N];
  logic [15:0] drp_mem [128];
  logic [15:0] ref_mem [128];
  txn_t exp_q[$];
  res_t res_q[$];

  // responder / lock model knobs
  int lat = 1;
  int drop_den = -1;
  bit spurious = 1'b0;
  bit resp_clear = 1'b0;
  int resp_count = 0;
  int lock_delay = 10;
  bit lock_hold0 = 1'b0;
  bit stale_lock = 1'b0;

  // monitor state
  int cyc = 0;
  int den_count = 0;
  int last_den_cyc = 0;
  int mrst_fall_cyc = 0;
  logic prev_mrst = 1'b0;
  logic prev_den = 1'b0;
  logic prev_done = 1'b0;
  logic [AW-1:0] tbl_addr_q = '0;

  function automatic void chk(bit ok, string name, string info);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, info);
    end
  endfunction

  // reference: apply the table entries by the RMW rule, queue the DRP traffic
  function automatic void plan(int full, bit extra_read);
    for (int i = 0; i < full; i++) begin
      logic [6:0]  a;
      logic [15:0] m, d, nv;
      a  = table_mem[i][38:32];
      m  = table_mem[i][31:16];
      d  = table_mem[i][15:0];
      nv = (ref_mem[a] & m) | (d & ~m);
      exp_q.push_back('{wr: 1'b0, addr: a, data: 16'h0});
      exp_q.push_back('{wr: 1'b1, addr: a, data: nv});
      ref_mem[a] = nv;
    end
    if (extra_read)
      exp_q.push_back('{wr: 1'b0, addr: table_mem[full][38:32], data: 16'h0});
  endfunction

  function automatic void expect_result(logic e, logic [1:0] c);
    res_q.push_back('{err: e, code: c});
  endfunction

  function automatic void randomize_table();
    for (int i = 1; i < N; i++)
      table_mem[i] = {7'($urandom_range(16, 127)), 16'($urandom), 16'($urandom)};
  endfunction

  // table ROM: data follows the address by one cycle
  initial begin
    bus.tbl_data = '0;
    forever begin
      @(negedge clk);
      bus.tbl_data = (int'(tbl_addr_q) < N) ? table_mem[int'(tbl_addr_q)] : 39'h0;
      tbl_addr_q = bus.tbl_addr;
    end
  end

  // DRP responder: DRDY k cycles after DEN, optional drop and spurious DRDY
  initial begin
    int cd, spur;
    logic wr_pend;
    logic [15:0] rd_pend;
    cd = 0; spur = 0; wr_pend = 1'b0; rd_pend = '0;
    bus.drdy = 1'b0;
    bus.do_data = '0;
    forever begin
      @(negedge clk);
      bus.drdy = 1'b0;
      if (resp_clear) begin
        cd = 0; spur = 0; resp_clear = 1'b0;
      end
      if (spur > 0) begin
        spur--;
        bus.drdy = 1'b1;
        bus.do_data = 16'($urandom);
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.drdy = 1'b1;
          bus.do_data = wr_pend ? 16'($urandom) : rd_pend;
          if (wr_pend && spurious) spur = 2;
        end
      end
      if (bus.den === 1'b1) begin
        if (resp_count != drop_den) begin
          cd = lat;
          wr_pend = bus.dwe;
          if (bus.dwe) drp_mem[bus.daddr] = bus.di;
          else rd_pend = drp_mem[bus.daddr];
        end
        resp_count++;
      end
    end
  end

  // MMCM LOCKED model
  initial begin
    int lcnt;
    lcnt = 0;
    bus.locked = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mmcm_rst === 1'b1) begin
        lcnt = 0;
        bus.locked = stale_lock;
      end else if (lock_hold0) begin
        bus.locked = 1'b0;
      end else if (lcnt < lock_delay) begin
        lcnt++;
        bus.locked = 1'b0;
      end else begin
        bus.locked = 1'b1;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_mrst === 1'b1 && bus.mmcm_rst === 1'b0) mrst_fall_cyc = cyc;
      if (bus.dwe === 1'b1 && bus.den !== 1'b1)
        chk(1'b0, "dwe_without_den", $sformatf("dwe=%b den=%b", bus.dwe, bus.den));
      if (bus.den === 1'b1) begin
        den_count++;
        last_den_cyc = cyc;
        chk(prev_den !== 1'b1, "den_width", "den high two cycles running");
        chk(bus.mmcm_rst === 1'b1 && bus.busy === 1'b1, "rst_busy_during_drp",
            $sformatf("mmcm_rst=%b busy=%b want 1 1", bus.mmcm_rst, bus.busy));
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_den", $sformatf("wr=%b addr=%h", bus.dwe, bus.daddr));
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          chk(bus.dwe === t.wr && bus.daddr === t.addr && (!t.wr || bus.di === t.data),
              "drp_txn", $sformatf("got wr=%b addr=%h di=%h want wr=%b addr=%h di=%h",
              bus.dwe, bus.daddr, bus.di, t.wr, t.addr, t.data));
        end
      end
      if (bus.done === 1'b1) begin
        chk(prev_done !== 1'b1, "done_width", "done high two cycles running");
        if (res_q.size() == 0) begin
          chk(1'b0, "unexpected_done", $sformatf("err=%b code=%0d", bus.err, bus.err_code));
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk(bus.err === r.err && bus.err_code === r.code, "result",
              $sformatf("got err=%b code=%0d want err=%b code=%0d",
              bus.err, bus.err_code, r.err, r.code));
          chk(exp_q.size() == 0, "txns_complete",
              $sformatf("%0d DRP transactions still expected", exp_q.size()));
          chk(bus.busy === 1'b1 && bus.mmcm_rst === 1'b0, "done_flags",
              $sformatf("busy=%b mmcm_rst=%b want 1 0", bus.busy, bus.mmcm_rst));
          if (r.code == 2'd1)
            chk(cyc - last_den_cyc == DT, "drdy_timeout_delay",
                $sformatf("got %0d want %0d", cyc - last_den_cyc, DT));
          if (r.code == 2'd2)
            chk(cyc - mrst_fall_cyc == LT, "lock_timeout_delay",
                $sformatf("got %0d want %0d", cyc - mrst_fall_cyc, LT));
        end
      end
      prev_mrst = bus.mmcm_rst;
      prev_den  = bus.den;
      prev_done = bus.done;
    end
  end

  task automatic start_seq();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk(bus.busy === 1'b1 && bus.mmcm_rst === 1'b1 && bus.err === 1'b0 &&
        bus.err_code === 2'd0 && bus.tbl_addr === '0, "post_start",
        $sformatf("busy=%b mmcm_rst=%b err=%b code=%0d tbl_addr=%0d want 1 1 0 0 0",
        bus.busy, bus.mmcm_rst, bus.err, bus.err_code, bus.tbl_addr));
  endtask

  task automatic wait_done(bit spam);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (spam) bus.start = ($urandom_range(0, 5) == 0);
    end
    bus.start = 1'b0;
    chk(got, "done_seen", "no done within 3000 cycles");
    @(negedge clk);
    chk(bus.busy === 1'b0, "busy_after_done", $sformatf("busy=%b want 0", bus.busy));
  endtask

  initial begin
    int base;
    bit mem_ok, seen;
    bus.start = 1'b0;

    for (int i = 0; i < 128; i++) begin
      drp_mem[i] = 16'($urandom);
      ref_mem[i] = drp_mem[i];
    end
    drp_mem[8] = 16'hF3C7;
    ref_mem[8] = 16'hF3C7;
    table_mem[0] = {7'h08, 16'h1000, 16'h0041};
    randomize_table();

    repeat (3) @(negedge clk);
    chk(bus.busy === 1'b0 && bus.done === 1'b0 && bus.err === 1'b0 && bus.den === 1'b0 &&
        bus.dwe === 1'b0 && bus.mmcm_rst === 1'b0 && bus.err_code === 2'd0 &&
        bus.daddr === '0 && bus.di === '0 && bus.tbl_addr === '0, "reset_values",
        $sformatf("busy=%b done=%b err=%b den=%b dwe=%b mmcm_rst=%b code=%0d daddr=%h di=%h ta=%0d",
        bus.busy, bus.done, bus.err, bus.den, bus.dwe, bus.mmcm_rst, bus.err_code,
        bus.daddr, bus.di, bus.tbl_addr));
    rst = 1'b0;

    // run 1: latency 3, LOCKED 10 cycles after release; entry 0 is the known RMW
    lat = 3;
    plan(N, 1'b0);
    expect_result(1'b0, 2'd0);
    start_seq();
    wait_done(1'b0);
    chk(drp_mem[8] === 16'h1041, "entry0_rmw", $sformatf("got %h want 1041", drp_mem[8]));

    // run 2: latency 1, stale LOCKED, START spam and spurious DRDY
    lat = 1; stale_lock = 1'b1; spurious = 1'b1;
    randomize_table();
    base = den_count;
    plan(N, 1'b0);
    expect_result(1'b0, 2'd0);
    start_seq();
    wait_done(1'b1);
    chk(den_count - base == 2 * N, "den_total", $sformatf("got %0d want %0d", den_count - base, 2 * N));
    mem_ok = 1'b1;
    for (int i = 0; i < 128; i++) if (drp_mem[i] !== ref_mem[i]) mem_ok = 1'b0;
    chk(mem_ok, "final_mem", "DRP register contents differ from reference");
    stale_lock = 1'b0; spurious = 1'b0;

    // run 3: DRDY never returns for the read of entry 5
    randomize_table();
    base = den_count;
    drop_den = resp_count + 10;
    plan(5, 1'b1);
    expect_result(1'b1, 2'd1);
    start_seq();
    wait_done(1'b0);
    repeat (20) @(negedge clk);
    chk(den_count - base == 11, "no_den_after_timeout", $sformatf("got %0d want 11", den_count - base));
    chk(bus.err === 1'b1 && bus.err_code === 2'd1, "err_sticky",
        $sformatf("err=%b code=%0d want 1 1", bus.err, bus.err_code));
    drop_den = -1;

    // run 4: LOCKED held low, then a clean rerun clears ERR
    lock_hold0 = 1'b1;
    plan(N, 1'b0);
    expect_result(1'b1, 2'd2);
    start_seq();
    wait_done(1'b0);
    lock_hold0 = 1'b0;
    plan(N, 1'b0);
    expect_result(1'b0, 2'd0);
    start_seq();
    wait_done(1'b0);
    chk(bus.err === 1'b0 && bus.err_code === 2'd0, "err_cleared",
        $sformatf("err=%b code=%0d want 0 0", bus.err, bus.err_code));

    // run 5: reset during WR_WAIT of entry 2
    lat = 5;
    randomize_table();
    base = den_count;
    plan(3, 1'b0);
    start_seq();
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (den_count - base >= 6) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, "reach_entry2_write", $sformatf("saw %0d DEN want 6", den_count - base));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk(bus.mmcm_rst === 1'b0 && bus.busy === 1'b0 && bus.den === 1'b0 &&
        bus.done === 1'b0 && bus.err === 1'b0 && bus.tbl_addr === '0, "mid_reset",
        $sformatf("mmcm_rst=%b busy=%b den=%b done=%b err=%b ta=%0d",
        bus.mmcm_rst, bus.busy, bus.den, bus.done, bus.err, bus.tbl_addr));
    rst = 1'b0;
    resp_clear = 1'b1;
    chk(exp_q.size() == 0, "reset_txn_count", $sformatf("%0d left", exp_q.size()));
    repeat (5) @(negedge clk);
    lat = 1;
    plan(N, 1'b0);
    expect_result(1'b0, 2'd0);
    start_seq();
    wait_done(1'b0);

    chk(exp_q.size() == 0 && res_q.size() == 0, "queues_drained",
        $sformatf("txn=%0d res=%0d", exp_q.size(), res_q.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule
